// File: rtl/lock_pkg.sv
// Shared definitions for the digital lock: state encoding, special keys and
// the digit-packing convention (digit i lives in code[4i+3:4i]).
package lock_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_ARM     = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROG    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  localparam logic [3:0] ENTER_BUTTON = 4'hF;
  localparam logic [3:0] PROG_BUTTON  = 4'hE;
  localparam int         MAX_DIGITS   = 6;
  localparam int         DIGIT_W      = 4;
  localparam int         CODE_W       = MAX_DIGITS * DIGIT_W;

  // Returns code with the nibble at position idx replaced by digit.
  function automatic logic [CODE_W-1:0] put_digit(input logic [CODE_W-1:0] code,
                                                  input logic [2:0]        idx,
                                                  input logic [3:0]        digit);
    logic [CODE_W-1:0] r;
    r = code;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (idx == 3'(i)) r[i*DIGIT_W +: DIGIT_W] = digit;
    end
    return r;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; expire pulses for one cycle when the count reaches 1,
// so a load of N yields exactly N cycles before the owner moves on.
module lock_timer #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - ONE;
  end

  assign expire = (cnt == ONE);

endmodule

// File: rtl/lock_controller.sv
// Top-level lock sequencer: arms the code checker, applies the unlock window,
// failed-attempt lockout and the programming mode that replaces the stored code.
module lock_controller
  import lock_pkg::*;
#(
  parameter int                MAX_TRIES      = 3,
  parameter int                OPEN_CYCLES    = 8,
  parameter int                LOCKOUT_CYCLES = 16,
  parameter logic [CODE_W-1:0] DEFAULT_CODE   = 24'h000321,
  parameter int                DEFAULT_LENGTH = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        BUTTON,
  input  logic              BPRESS,
  input  logic              CHK_DONE,
  input  logic              CHK_SUCCESS,
  output logic              CHK_GO,
  output logic [CODE_W-1:0] CODE,
  output logic [2:0]        LENGTH,
  output logic              UNLOCKED,
  output logic              LOCKED_OUT,
  output logic              PROG_MODE,
  output logic [2:0]        FAIL_COUNT
);

  localparam int         TMAX     = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int         TW       = $clog2(TMAX + 1);
  localparam logic [2:0] LAST_TRY = 3'(MAX_TRIES - 1);
  localparam logic [2:0] DIG_MAX  = 3'(MAX_DIGITS);

  state_t            state, state_nx;
  logic              t_load, t_exp;
  logic [TW-1:0]     t_val;
  logic [CODE_W-1:0] code_r, prog_buf;
  logic [2:0]        len_r, dig_cnt, fail_cnt;

  logic press_prog, press_enter, press_digit, verdict_ok, verdict_bad, last_try;

  assign press_prog  = BPRESS && (BUTTON == PROG_BUTTON);
  assign press_enter = BPRESS && (BUTTON == ENTER_BUTTON);
  assign press_digit = BPRESS && !press_prog && !press_enter;
  assign verdict_ok  = CHK_DONE && CHK_SUCCESS;
  assign verdict_bad = CHK_DONE && !CHK_SUCCESS;
  assign last_try    = (fail_cnt == LAST_TRY);

  // OPEN and LOCKOUT never overlap, so one timer serves both windows.
  lock_timer #(.W(TW)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_exp)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= S_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:    state_nx = S_ARM;
      S_ARM:     state_nx = S_CHECK;
      S_CHECK: begin
        if (verdict_ok)       state_nx = S_OPEN;
        else if (verdict_bad) state_nx = last_try ? S_LOCKOUT : S_ARM;
      end
      // A PROG press on the expiry cycle takes priority over closing.
      S_OPEN: begin
        if (press_prog)       state_nx = S_PROG;
        else if (t_exp)       state_nx = S_ARM;
      end
      S_PROG: begin
        if (press_enter || press_prog) state_nx = S_ARM;
      end
      S_LOCKOUT: begin
        if (t_exp)            state_nx = S_ARM;
      end
      default:                state_nx = S_INIT;
    endcase
  end

  always_comb begin
    t_load = (state == S_CHECK) && (verdict_ok || (verdict_bad && last_try));
    t_val  = CHK_SUCCESS ? TW'(OPEN_CYCLES) : TW'(LOCKOUT_CYCLES);
  end

  always_comb begin
    CHK_GO     = 1'b0;
    UNLOCKED   = 1'b0;
    LOCKED_OUT = 1'b0;
    PROG_MODE  = 1'b0;
    case (state)
      S_ARM:     CHK_GO     = 1'b1;
      S_OPEN:    UNLOCKED   = 1'b1;
      S_PROG: begin
        UNLOCKED  = 1'b1;
        PROG_MODE = 1'b1;
      end
      S_LOCKOUT: LOCKED_OUT = 1'b1;
      default: ;
    endcase
  end

  // Code/length only change on a PROG commit, when the checker is idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      code_r   <= DEFAULT_CODE;
      len_r    <= 3'(DEFAULT_LENGTH);
      fail_cnt <= '0;
      prog_buf <= '0;
      dig_cnt  <= '0;
    end else begin
      case (state)
        S_CHECK: begin
          if (verdict_ok)       fail_cnt <= '0;
          else if (verdict_bad) fail_cnt <= last_try ? 3'd0 : fail_cnt + 3'd1;
        end
        S_OPEN: begin
          if (press_prog) begin
            prog_buf <= '0;
            dig_cnt  <= '0;
          end
        end
        S_PROG: begin
          if (press_digit && (dig_cnt < DIG_MAX)) begin
            prog_buf <= put_digit(prog_buf, dig_cnt, BUTTON);
            dig_cnt  <= dig_cnt + 3'd1;
          end else if (press_enter && (dig_cnt != 3'd0)) begin
            code_r <= prog_buf;
            len_r  <= dig_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  assign CODE       = code_r;
  assign LENGTH     = len_r;
  assign FAIL_COUNT = fail_cnt;

endmodule

// File: tb/tb_lock_controller.sv
// Cycle-accurate bench for lock_controller: each step drives one cycle of inputs,
// queues the expected outputs and compares them once the clock edge has passed.
module tb_lock_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  BUTTON = 4'h0;
  logic        BPRESS = 1'b0;
  logic        CHK_DONE = 1'b0;
  logic        CHK_SUCCESS = 1'b0;
  logic        CHK_GO;
  logic [23:0] CODE;
  logic [2:0]  LENGTH;
  logic        UNLOCKED;
  logic        LOCKED_OUT;
  logic        PROG_MODE;
  logic [2:0]  FAIL_COUNT;

  lock_controller dut (
    .CLK         (CLK),
    .RST         (RST),
    .BUTTON      (BUTTON),
    .BPRESS      (BPRESS),
    .CHK_DONE    (CHK_DONE),
    .CHK_SUCCESS (CHK_SUCCESS),
    .CHK_GO      (CHK_GO),
    .CODE        (CODE),
    .LENGTH      (LENGTH),
    .UNLOCKED    (UNLOCKED),
    .LOCKED_OUT  (LOCKED_OUT),
    .PROG_MODE   (PROG_MODE),
    .FAIL_COUNT  (FAIL_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst;
    logic [3:0] btn;
    logic       bp;
    logic       dn;
    logic       ok;
  } in_t;

  typedef struct packed {
    logic        go;
    logic        unl;
    logic        lo;
    logic        pm;
    logic [2:0]  fc;
    logic [23:0] code;
    logic [2:0]  len;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  e;
  } vec_t;

  typedef struct {
    string nm;
    out_t  e;
  } sb_t;

  sb_t         sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_code;
  logic [2:0]  exp_len;

  function automatic in_t mk_in(logic rst, logic [3:0] btn, logic bp, logic dn, logic ok);
    in_t r;
    r.rst = rst; r.btn = btn; r.bp = bp; r.dn = dn; r.ok = ok;
    return r;
  endfunction

  function automatic out_t mk_out(logic go, logic unl, logic lo, logic pm, logic [2:0] fc);
    out_t r;
    r.go = go; r.unl = unl; r.lo = lo; r.pm = pm; r.fc = fc;
    r.code = exp_code; r.len = exp_len;
    return r;
  endfunction

  task automatic compare_next();
    sb_t  x;
    out_t got;
    got = {CHK_GO, UNLOCKED, LOCKED_OUT, PROG_MODE, FAIL_COUNT, CODE, LENGTH};
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=%h", got);
      return;
    end
    x = sb.pop_front();
    if (got !== x.e) begin
      failures++;
      $display("FAIL %s got go=%b unl=%b lo=%b pm=%b fc=%0d code=%h len=%0d want go=%b unl=%b lo=%b pm=%b fc=%0d code=%h len=%0d",
               x.nm, got.go, got.unl, got.lo, got.pm, got.fc, got.code, got.len,
               x.e.go, x.e.unl, x.e.lo, x.e.pm, x.e.fc, x.e.code, x.e.len);
    end
  endtask

  task automatic step(input string nm, input in_t i, input out_t e);
    sb_t x;
    @(negedge CLK);
    RST = i.rst; BUTTON = i.btn; BPRESS = i.bp; CHK_DONE = i.dn; CHK_SUCCESS = i.ok;
    x.nm = nm; x.e = e;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    compare_next();
  endtask

  task automatic idle(input string nm, input out_t e);
    step(nm, mk_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0), e);
  endtask

  task automatic press(input string nm, input logic [3:0] b, input out_t e);
    step(nm, mk_in(1'b0, b, 1'b1, 1'b0, 1'b0), e);
  endtask

  task automatic verdict(input string nm, input logic ok, input out_t e);
    step(nm, mk_in(1'b0, 4'h0, 1'b0, 1'b1, ok), e);
  endtask

  vec_t tbl[5];

  initial begin
    exp_code = 24'h000321;
    exp_len  = 3'd3;
    tbl[0] = '{nm:"reset_init",   i:mk_in(1, 4'h0, 0, 0, 0), e:mk_out(0, 0, 0, 0, 3'd0)};
    tbl[1] = '{nm:"first_go",     i:mk_in(0, 4'h0, 0, 0, 0), e:mk_out(1, 0, 0, 0, 3'd0)};
    tbl[2] = '{nm:"check_wait",   i:mk_in(0, 4'h0, 0, 0, 0), e:mk_out(0, 0, 0, 0, 3'd0)};
    tbl[3] = '{nm:"check_press",  i:mk_in(0, 4'hE, 1, 0, 0), e:mk_out(0, 0, 0, 0, 3'd0)};
    tbl[4] = '{nm:"success_open", i:mk_in(0, 4'h0, 0, 1, 1), e:mk_out(0, 1, 0, 0, 3'd0)};

    for (int k = 0; k < 5; k++) step(tbl[k].nm, tbl[k].i, tbl[k].e);

    // Unlock window: 8 cycles total, stray verdict and digit ignored
    for (int k = 1; k < 8; k++) begin
      if (k == 3)      verdict("open_stray_done", 1'b0, mk_out(0, 1, 0, 0, 3'd0));
      else if (k == 5) press("open_digit_ignored", 4'h5, mk_out(0, 1, 0, 0, 3'd0));
      else             idle("open_hold", mk_out(0, 1, 0, 0, 3'd0));
    end
    idle("open_expire_arm", mk_out(1, 0, 0, 0, 3'd0));
    idle("arm_to_check", mk_out(0, 0, 0, 0, 3'd0));

    // Three failures -> lockout
    verdict("fail1", 1'b0, mk_out(1, 0, 0, 0, 3'd1));
    idle("check_fc1", mk_out(0, 0, 0, 0, 3'd1));
    verdict("fail2", 1'b0, mk_out(1, 0, 0, 0, 3'd2));
    idle("check_fc2", mk_out(0, 0, 0, 0, 3'd2));
    verdict("fail3_lockout", 1'b0, mk_out(0, 0, 1, 0, 3'd0));
    for (int k = 2; k <= 16; k++) begin
      if (k % 3 == 0)      verdict("lockout_done_ignored", 1'b1, mk_out(0, 0, 1, 0, 3'd0));
      else if (k % 3 == 1) press("lockout_prog_ignored", 4'hE, mk_out(0, 0, 1, 0, 3'd0));
      else                 press("lockout_digit_ignored", 4'h4, mk_out(0, 0, 1, 0, 3'd0));
    end
    idle("lockout_end_arm", mk_out(1, 0, 0, 0, 3'd0));
    idle("post_lockout_check", mk_out(0, 0, 0, 0, 3'd0));

    // Reprogram to 4,5,6,7
    verdict("open_for_prog1", 1'b1, mk_out(0, 1, 0, 0, 3'd0));
    press("enter_prog1", 4'hE, mk_out(0, 1, 0, 1, 3'd0));
    press("prog1_d4", 4'h4, mk_out(0, 1, 0, 1, 3'd0));
    press("prog1_d5", 4'h5, mk_out(0, 1, 0, 1, 3'd0));
    press("prog1_d6", 4'h6, mk_out(0, 1, 0, 1, 3'd0));
    press("prog1_d7", 4'h7, mk_out(0, 1, 0, 1, 3'd0));
    exp_code = 24'h007654; exp_len = 3'd4;
    press("prog1_commit", 4'hF, mk_out(1, 0, 0, 0, 3'd0));
    idle("prog1_check", mk_out(0, 0, 0, 0, 3'd0));

    // Seven digits: seventh dropped
    verdict("open_for_prog2", 1'b1, mk_out(0, 1, 0, 0, 3'd0));
    press("enter_prog2", 4'hE, mk_out(0, 1, 0, 1, 3'd0));
    for (int d = 1; d <= 7; d++) press("prog2_digit", 4'(d), mk_out(0, 1, 0, 1, 3'd0));
    exp_code = 24'h654321; exp_len = 3'd6;
    press("prog2_commit", 4'hF, mk_out(1, 0, 0, 0, 3'd0));
    idle("prog2_check", mk_out(0, 0, 0, 0, 3'd0));

    // Abort: E,F with no digits
    verdict("open_abort1", 1'b1, mk_out(0, 1, 0, 0, 3'd0));
    press("abort1_prog", 4'hE, mk_out(0, 1, 0, 1, 3'd0));
    press("abort1_empty_enter", 4'hF, mk_out(1, 0, 0, 0, 3'd0));
    idle("abort1_check", mk_out(0, 0, 0, 0, 3'd0));

    // Abort: E,3,E
    verdict("open_abort2", 1'b1, mk_out(0, 1, 0, 0, 3'd0));
    press("abort2_prog", 4'hE, mk_out(0, 1, 0, 1, 3'd0));
    press("abort2_d3", 4'h3, mk_out(0, 1, 0, 1, 3'd0));
    press("abort2_prog_again", 4'hE, mk_out(1, 0, 0, 0, 3'd0));
    idle("abort2_check", mk_out(0, 0, 0, 0, 3'd0));

    // PROG press on the expiry cycle wins
    verdict("open_expiry_prog", 1'b1, mk_out(0, 1, 0, 0, 3'd0));
    for (int k = 2; k <= 8; k++) idle("expiry_open_hold", mk_out(0, 1, 0, 0, 3'd0));
    press("expiry_prog_wins", 4'hE, mk_out(0, 1, 0, 1, 3'd0));
    idle("prog_no_timeout", mk_out(0, 1, 0, 1, 3'd0));
    press("expiry_abort", 4'hF, mk_out(1, 0, 0, 0, 3'd0));
    idle("expiry_check", mk_out(0, 0, 0, 0, 3'd0));

    // Commit 9,9 then reset mid-PROG
    verdict("open_prog99", 1'b1, mk_out(0, 1, 0, 0, 3'd0));
    press("prog99_enter", 4'hE, mk_out(0, 1, 0, 1, 3'd0));
    press("prog99_d9a", 4'h9, mk_out(0, 1, 0, 1, 3'd0));
    press("prog99_d9b", 4'h9, mk_out(0, 1, 0, 1, 3'd0));
    exp_code = 24'h000099; exp_len = 3'd2;
    press("prog99_commit", 4'hF, mk_out(1, 0, 0, 0, 3'd0));
    idle("prog99_check", mk_out(0, 0, 0, 0, 3'd0));
    verdict("open_before_reset", 1'b1, mk_out(0, 1, 0, 0, 3'd0));
    press("prog_before_reset", 4'hE, mk_out(0, 1, 0, 1, 3'd0));
    exp_code = 24'h000321; exp_len = 3'd3;
    step("reset_mid_prog", mk_in(1, 4'h0, 0, 0, 0), mk_out(0, 0, 0, 0, 3'd0));
    idle("reset_go_again", mk_out(1, 0, 0, 0, 3'd0));
    idle("reset_check", mk_out(0, 0, 0, 0, 3'd0));

    // Reset clears a nonzero fail count
    verdict("fail_before_reset", 1'b0, mk_out(1, 0, 0, 0, 3'd1));
    idle("check_fc_before_reset", mk_out(0, 0, 0, 0, 3'd1));
    step("reset_clears_fc", mk_in(1, 4'h0, 0, 0, 0), mk_out(0, 0, 0, 0, 3'd0));
    idle("reset2_go", mk_out(1, 0, 0, 0, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
